// File: rtl/aes_out_buffer.sv
// aes_out_buffer: output-side receiver for the fixed-latency AES pipeline.
// Captures every pipeline result into a show-ahead FIFO, presents it on a
// valid/ready handshake, and grants issue credit only while every block in
// flight is guaranteed a FIFO slot.
// Optional feature: define AES_OUTBUF_STATS_EN to build the delivered-block
// counter on blk_cnt; otherwise blk_cnt is tied to zero.
module aes_out_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_vld,
    output logic                     issue_rdy,
    input  logic                     pipe_vin,
    input  logic                     pipe_tin,
    input  logic [127:0]             pipe_din,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_type,
    output logic [127:0]             out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   inflight,
    output logic                     err,
    output logic [31:0]              blk_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] CREDIT_L = (AW+2)'(DEPTH);

    logic [128:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   inflight_q, inflight_d;
    logic          err_q, err_d;

    logic full, pop, push, issue;

    assign full  = (count_q == FULL);
    assign pop   = (count_q != '0) & out_rdy;
    // A push into a full FIFO is only accepted when the head leaves this cycle.
    assign push  = pipe_vin & (~full | pop);
    // Credit is a pure function of registers so no input can reach issue_rdy.
    assign issue_rdy = ({1'b0, inflight_q} + {1'b0, count_q}) < CREDIT_L;
    assign issue     = issue_vld & issue_rdy;

    assign out_vld  = (count_q != '0);
    assign out_type = mem_q[rd_ptr_q][128];
    assign out_data = mem_q[rd_ptr_q][127:0];
    assign count    = count_q;
    assign inflight = inflight_q;
    assign err      = err_q;

    // Next-state for occupancy, credits and the sticky error flag.
    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (!push && pop)
            count_d = count_q - 1'b1;

        inflight_d = inflight_q;
        if (issue && !pipe_vin)
            inflight_d = inflight_q + 1'b1;
        else if (!issue && pipe_vin && inflight_q != '0)
            inflight_d = inflight_q - 1'b1;

        // A return nobody issued, or a result with nowhere to go, is a protocol error.
        err_d = err_q
              | (pipe_vin & (inflight_q == '0))
              | (pipe_vin & ~push);
    end

    // Control registers; reset discards all contents and credits at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Storage array; cleared on reset so the head reads zero immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= {pipe_tin, pipe_din};
        end
    end

`ifdef AES_OUTBUF_STATS_EN
    logic [31:0] blk_cnt_q;

    // Delivered-block counter, wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            blk_cnt_q <= '0;
        else if (pop)
            blk_cnt_q <= blk_cnt_q + 32'd1;
    end

    assign blk_cnt = blk_cnt_q;
`else
    assign blk_cnt = '0;
`endif

endmodule
